// File: rtl/fetch_defs.sv
// rtl/fetch_defs.sv - shared state encoding and instruction field positions for the fetch unit
package fetch_defs;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } fetch_state_e;

    localparam int OPCODE_HI  = 15;
    localparam int OPCODE_LO  = 12;
    localparam int PAYLOAD_HI = 11;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter register; a jump load beats an increment, and increments wrap
module program_counter #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] reset_vector_i,
    input  logic                  load_en_i,
    input  logic [ADDR_WIDTH-1:0] load_target_i,
    input  logic                  incr_en_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en_i) begin
            pc_d = load_target_i;
        end else if (incr_en_i) begin
            pc_d = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= reset_vector_i;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - three-phase fetch FSM feeding a held instruction register to decode
module instruction_fetch_unit
    import fetch_defs::*;
#(
    parameter int                   ADDR_WIDTH   = 16,
    parameter int                   INSTR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   pc_increment,
    input  logic                   jump_valid,
    input  logic [ADDR_WIDTH-1:0]  jump_target,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [15:0]            retired_count
);

    fetch_state_e           state_q;
    fetch_state_e           state_d;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [15:0]            retired_q;
    logic [ADDR_WIDTH-1:0]  pc_w;
    logic                   consume;

    // Control-word inputs only matter on the edge that retires the held instruction.
    assign consume = (state_q == HOLD) && instr_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = HOLD;
            HOLD:    if (instr_ready) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH;
            instr_q   <= '0;
            retired_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == CAPTURE) begin
                instr_q <= imem_rdata;
            end
            if (consume) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    program_counter #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_program_counter (
        .clock         (clock),
        .reset         (reset),
        .reset_vector_i(RESET_VECTOR),
        .load_en_i     (consume && jump_valid),
        .load_target_i (jump_target),
        .incr_en_i     (consume && pc_increment),
        .pc_o          (pc_w)
    );

    assign imem_addr     = pc_w;
    assign pc            = pc_w;
    assign instr         = instr_q;
    assign instr_valid   = (state_q == HOLD);
    assign retired_count = retired_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for the instruction fetch unit
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_increment;
    logic        jump_valid;
    logic [15:0] jump_target;
    logic [15:0] pc;
    logic [15:0] retired_count;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] m_pc;
    logic [15:0] m_ret;

    instruction_fetch_unit #(
        .ADDR_WIDTH  (16),
        .INSTR_WIDTH (16),
        .RESET_VECTOR(16'h0000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_increment (pc_increment),
        .jump_valid   (jump_valid),
        .jump_target  (jump_target),
        .pc           (pc),
        .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0001: return 16'h0A5C;
            16'h0100: return 16'hBEEF;
            default:  return {a[7:0], a[15:8]} ^ 16'h5A5A;
        endcase
    endfunction

    always @(posedge clock) imem_rdata <= mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (instr_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                check_eq("sb_empty", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("sb_pc", pc, e.pc);
                check_eq("sb_instr", instr, e.instr);
                check_eq("sb_retired", retired_count, e.ret);
            end
        end
        prev_valid <= instr_valid;
    end

    task automatic release_and_first();
        int n;
        reset = 1'b0;
        m_pc  = 16'h0000;
        m_ret = 16'h0000;
        sb.push_back('{pc: m_pc, instr: mem_word(m_pc), ret: m_ret});
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!instr_valid && n < 8);
        check_eq("reset_to_valid_latency", n, 2);
    endtask

    task automatic consume(input logic inc, input logic jv, input logic [15:0] jt,
                           input bit abort_in_capture);
        int n;
        if (jv) m_pc = jt;
        else if (inc) m_pc = m_pc + 16'd1;
        m_ret = m_ret + 16'd1;
        if (!abort_in_capture) sb.push_back('{pc: m_pc, instr: mem_word(m_pc), ret: m_ret});
        instr_ready  = 1'b1;
        pc_increment = inc;
        jump_valid   = jv;
        jump_target  = jt;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                check_eq("fetch_addr", imem_addr, m_pc);
                pc_increment = 1'($urandom);
                jump_valid   = 1'($urandom);
                jump_target  = 16'($urandom);
            end
            if (abort_in_capture && n == 2) begin
                reset       = 1'b1;
                instr_ready = 1'b0;
                @(negedge clock);
                check_eq("abort_instr", instr, 16'h0000);
                check_eq("abort_valid", instr_valid, 1'b0);
                check_eq("abort_pc", pc, 16'h0000);
                check_eq("abort_retired", retired_count, 16'h0000);
                return;
            end
        end while (!instr_valid && n < 8);
        instr_ready = 1'b0;
        check_eq("consume_to_valid_latency", n, 3);
    endtask

    initial begin
        int changes;
        logic [15:0] s_instr, s_pc, s_addr;
        reset        = 1'b1;
        instr_ready  = 1'b0;
        pc_increment = 1'b0;
        jump_valid   = 1'b0;
        jump_target  = 16'h0000;
        repeat (3) @(negedge clock);
        check_eq("rst_instr", instr, 16'h0000);
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_pc", pc, 16'h0000);
        check_eq("rst_addr", imem_addr, 16'h0000);
        check_eq("rst_retired", retired_count, 16'h0000);

        release_and_first();
        consume(1'b1, 1'b0, 16'h0000, 1'b0);
        consume(1'b1, 1'b1, 16'h0040, 1'b0);

        s_instr = instr;
        s_pc    = pc;
        s_addr  = imem_addr;
        changes = 0;
        repeat (10) begin
            @(negedge clock);
            if (instr !== s_instr || pc !== s_pc || imem_addr !== s_addr || instr_valid !== 1'b1)
                changes++;
        end
        check_eq("hold_stable", changes, 0);

        consume(1'b0, 1'b0, 16'h0000, 1'b0);
        consume(1'b1, 1'b1, 16'hFFFF, 1'b0);
        consume(1'b1, 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < 8; i++) begin
            consume(1'($urandom), ($urandom_range(3) == 0), 16'($urandom), 1'b0);
            repeat ($urandom_range(2)) @(negedge clock);
        end

        consume(1'b0, 1'b1, 16'h0100, 1'b1);
        @(negedge clock);
        release_and_first();

        @(negedge clock);
        check_eq("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
